// File: rtl/store_beat_splitter.sv
// Store path from EX/MEM to the data-memory port: turns one right-justified store into
// one or two bus-aligned beats (address, byte mask, lane-shifted data) with valid/ready on both sides.
package CorePack;
   typedef enum logic [2:0] {
      MEM_NO, MEM_B, MEM_UB, MEM_H, MEM_UH, MEM_W, MEM_UW, MEM_D
   } mem_op_enum;
endpackage

// Handshakes: a transfer happens on a rising edge where valid & ready are both high;
// valid never drops and payload never changes while waiting for ready.
module store_beat_splitter #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 64,
   parameter int SPLIT_EN = 1,
   parameter int CNT_W    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  CorePack::mem_op_enum      req_op,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_data,
   output logic                      dmem_valid,
   input  logic                      dmem_ready,
   output logic [ADDR_W-1:0]         dmem_waddr,
   output logic [DATA_W/8-1:0]       dmem_wmask,
   output logic [DATA_W-1:0]         dmem_wdata,
   output logic                      done,
   output logic                      misalign,
   output logic [CNT_W-1:0]          split_cnt
);
   import CorePack::*;

   localparam int NB = DATA_W / 8;
   localparam int OW = $clog2(NB);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
   state_t state, next_state;

   logic                accept;
   logic [3:0]          size;
   logic [OW-1:0]       offs;
   logic [4:0]          span;
   logic                crosses;
   logic                fault;
   logic [ADDR_W-1:0]   base;
   logic [2*NB-1:0]     size_mask;
   logic [2*NB-1:0]     wide_mask;
   logic [DATA_W-1:0]   data_trim;
   logic [2*DATA_W-1:0] wide_data;

   logic                split_q;
   logic [ADDR_W-1:0]   b1_addr;
   logic [NB-1:0]       b1_mask;
   logic [DATA_W-1:0]   b1_data;

   logic                ready_n, valid_n, done_n, mis_n;
   logic [ADDR_W-1:0]   addr_n;
   logic [NB-1:0]       mask_n;
   logic [DATA_W-1:0]   data_n;

   assign accept = req_valid & req_ready;

   // Decode: both beats come out of one double-width shift; the upper half is beat 1.
   always_comb begin
      size = 4'd0;
      case (req_op)
         MEM_B, MEM_UB: size = 4'd1;
         MEM_H, MEM_UH: size = 4'd2;
         MEM_W, MEM_UW: size = 4'd4;
         MEM_D:         size = 4'd8;
         default:       size = 4'd0;
      endcase
      offs    = req_addr[OW-1:0];
      span    = 5'(offs) + 5'(size);
      crosses = span > 5'(NB);
      fault   = ((req_op == MEM_D) && (NB < 8)) || (crosses && (SPLIT_EN == 0));
      base    = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
      size_mask = '0;
      for (int i = 0; i < 2 * NB; i++) size_mask[i] = (i < int'(size));
      data_trim = '0;
      for (int i = 0; i < NB; i++)
         data_trim[8*i +: 8] = (i < int'(size)) ? req_data[8*i +: 8] : 8'h00;
      wide_mask = size_mask << offs;
      wide_data = {{DATA_W{1'b0}}, data_trim} << {offs, 3'b000};
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (accept) begin
                   if (req_op == MEM_NO || fault) next_state = RESP;
                   else                           next_state = BEAT0;
                end
         BEAT0: if (dmem_ready) next_state = split_q ? BEAT1 : RESP;
         BEAT1: if (dmem_ready) next_state = RESP;
         RESP:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are computed from the upcoming state and registered, so every port is a flop.
   always_comb begin
      ready_n = (next_state == IDLE);
      valid_n = (next_state == BEAT0) || (next_state == BEAT1);
      done_n  = (next_state == RESP);
      mis_n   = (state == IDLE) && accept && fault && (req_op != MEM_NO);
      addr_n  = '0;
      mask_n  = '0;
      data_n  = '0;
      if (state == IDLE && next_state == BEAT0) begin
         addr_n = base;
         mask_n = wide_mask[NB-1:0];
         data_n = wide_data[DATA_W-1:0];
      end else if (state == BEAT0 && next_state == BEAT1) begin
         addr_n = b1_addr;
         mask_n = b1_mask;
         data_n = b1_data;
      end else if (valid_n) begin
         addr_n = dmem_waddr;
         mask_n = dmem_wmask;
         data_n = dmem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready  <= 1'b1;
         dmem_valid <= 1'b0;
         dmem_waddr <= '0;
         dmem_wmask <= '0;
         dmem_wdata <= '0;
         done       <= 1'b0;
         misalign   <= 1'b0;
         split_cnt  <= '0;
         split_q    <= 1'b0;
         b1_addr    <= '0;
         b1_mask    <= '0;
         b1_data    <= '0;
      end else begin
         req_ready  <= ready_n;
         dmem_valid <= valid_n;
         dmem_waddr <= addr_n;
         dmem_wmask <= mask_n;
         dmem_wdata <= data_n;
         done       <= done_n;
         misalign   <= mis_n;
         if (state == IDLE && accept) begin
            split_q <= crosses;
            b1_addr <= base + ADDR_W'(NB);
            b1_mask <= wide_mask[2*NB-1:NB];
            b1_data <= wide_data[2*DATA_W-1:DATA_W];
         end
         if (state == BEAT1 && dmem_ready && split_cnt != '1)
            split_cnt <= split_cnt + 1'b1;
      end
   end
endmodule
